// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared Lisp heap definitions for the memory arbiter slice.
// Holds the tagged-word constants, arbiter state/op enums and a width helper.
package mem_arbiter_pkg;

  localparam logic [2:0]  TYPE_NIL  = 3'd0;
  localparam logic [2:0]  TYPE_CONS = 3'd1;
  localparam logic [15:0] LISP_NIL  = {1'b0, TYPE_NIL, 12'h000};

  typedef enum logic [2:0] {
    ArbIdle,
    ArbRdIssue,
    ArbRdWait,
    ArbConsIssue,
    ArbConsWait
  } arb_state_t;

  typedef enum logic {
    MemOpRead,
    MemOpCons
  } mem_op_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Scans upward from the entry
// after lastGrant with wrap-around and reports the first active requester.
module rr_arbiter #(
  parameter int NumReq = 2,
  parameter int IdxW   = 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_grant_i,
  output logic [IdxW-1:0]   grant_o,
  output logic              valid_o
);

  logic [IdxW-1:0] candIdx;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    candIdx = '0;
    for (int off = NumReq; off >= 1; off--) begin
      candIdx = IdxW'((int'(last_grant_i) + off) % NumReq);
      if (req_i[candIdx]) begin
        grant_o = candIdx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port Lisp heap (read + cons-allocate) between
// NumClients requesters with round-robin grant, one transaction in flight.
// Optional watchdog on the wait states is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NumClients    = 2,
  parameter int AddrWidth     = 12,
  parameter int WordWidth     = 16,
  parameter int TimeoutCycles = 15
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NumClients-1:0]           cl_req,
  input  logic [NumClients-1:0]           cl_is_cons,
  input  logic [NumClients*AddrWidth-1:0] cl_addr,
  input  logic [NumClients*WordWidth-1:0] cl_car,
  input  logic [NumClients*WordWidth-1:0] cl_cdr,
  output logic [NumClients-1:0]           cl_ack,
  output logic [WordWidth-1:0]            cl_rdata,
  output logic                            busy,
  output logic                            mem_req,
  output logic [AddrWidth-1:0]            mem_addr,
  input  logic                            mem_data_ready,
  input  logic [WordWidth-1:0]            mem_data_out,
  output logic                            mem_cons_en,
  output logic [WordWidth-1:0]            mem_cons_car,
  output logic [WordWidth-1:0]            mem_cons_cdr,
  input  logic                            mem_cons_done,
  input  logic [WordWidth-1:0]            mem_cons_ptr
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                            timeout_err
`endif
);

  localparam int IdxW = idxWidth(NumClients);

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       lastGrant_q, lastGrant_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [WordWidth-1:0]  car_q, car_d;
  logic [WordWidth-1:0]  cdr_q, cdr_d;
  logic                  memReq_q, memReq_d;
  logic                  consEn_q, consEn_d;
  logic [NumClients-1:0] ack_q, ack_d;
  logic [WordWidth-1:0]  rdata_q, rdata_d;
  logic                  busy_q, busy_d;

  logic [IdxW-1:0]       pick;
  logic                  pickValid;
  mem_op_t               pickOp;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  timeoutErr_q, timeoutErr_d;
  logic                  expired;
  assign expired = (cnt_q == CntW'(TimeoutCycles - 1));
`endif

  rr_arbiter #(
    .NumReq (NumClients),
    .IdxW   (IdxW)
  ) uRr (
    .req_i        (cl_req),
    .last_grant_i (lastGrant_q),
    .grant_o      (pick),
    .valid_o      (pickValid)
  );

  assign pickOp = cl_is_cons[pick] ? MemOpCons : MemOpRead;

  // Next-state logic: grant in idle, strobe the memory for one cycle, then wait for its reply.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    car_d       = car_q;
    cdr_d       = cdr_q;
    memReq_d    = 1'b0;
    consEn_d    = 1'b0;
    ack_d       = '0;
    rdata_d     = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeoutErr_d = timeoutErr_q;
`endif
    case (state_q)
      ArbIdle: begin
        if (pickValid) begin
          idx_d       = pick;
          lastGrant_d = pick;
          addr_d      = cl_addr[pick*AddrWidth +: AddrWidth];
          car_d       = cl_car[pick*WordWidth +: WordWidth];
          cdr_d       = cl_cdr[pick*WordWidth +: WordWidth];
          if (pickOp == MemOpCons) begin
            consEn_d = 1'b1;
            state_d  = ArbConsIssue;
          end else begin
            memReq_d = 1'b1;
            state_d  = ArbRdIssue;
          end
        end
      end
      ArbRdIssue: begin
        state_d = ArbRdWait;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ArbRdWait: begin
        if (mem_data_ready) begin
          rdata_d      = mem_data_out;
          ack_d[idx_q] = 1'b1;
          state_d      = ArbIdle;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expired) begin
          rdata_d      = WordWidth'(LISP_NIL);
          ack_d[idx_q] = 1'b1;
          timeoutErr_d = 1'b1;
          state_d      = ArbIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ArbConsIssue: begin
        state_d = ArbConsWait;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ArbConsWait: begin
        if (mem_cons_done) begin
          rdata_d      = mem_cons_ptr;
          ack_d[idx_q] = 1'b1;
          state_d      = ArbIdle;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expired) begin
          rdata_d      = WordWidth'(LISP_NIL);
          ack_d[idx_q] = 1'b1;
          timeoutErr_d = 1'b1;
          state_d      = ArbIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ArbIdle;
    endcase
    busy_d = (state_d != ArbIdle);
  end

  // State and output registers; reset drops any transaction in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ArbIdle;
      lastGrant_q <= IdxW'(NumClients - 1);
      idx_q       <= '0;
      addr_q      <= '0;
      car_q       <= '0;
      cdr_q       <= '0;
      memReq_q    <= 1'b0;
      consEn_q    <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      car_q       <= car_d;
      cdr_q       <= cdr_d;
      memReq_q    <= memReq_d;
      consEn_q    <= consEn_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  assign timeout_err = timeoutErr_q;
`endif

  assign cl_ack       = ack_q;
  assign cl_rdata     = rdata_q;
  assign busy         = busy_q;
  assign mem_req      = memReq_q;
  assign mem_addr     = addr_q;
  assign mem_cons_en  = consEn_q;
  assign mem_cons_car = car_q;
  assign mem_cons_cdr = cdr_q;

endmodule
